avion_boot_ctrl: RTL
====================

// Module: avion_boot_ctrl
// PURPOSE
//  Sequencer that owns the single blram port around avion_cpu: loads a program image, releases the CPU,
//  detects halt or timeout, then streams a result window out. Muxes the RAM port between itself and the CPU
//  and drives the CPU reset. Sits between the avion_cpu MAR/MDR/RAMWr pins and blram.
// PARAMETERS
//  ADDRESS_WIDTH 6     RAM address width
//  DATA_WIDTH    10    RAM word width
//  MEM_DEPTH     64    words loaded at most; load ends after address MEM_DEPTH-1
//  HALT_CYCLES   8     consecutive cycles of unchanged PC that mean halted
//  RUN_TIMEOUT   4096  max RUN cycles before forced stop
//  DUMP_BASE     52    first dumped address
//  DUMP_LEN      1     words dumped (0 = skip dump)
// PORTS
//  clk          in  1    clock
//  rst          in  1    asynchronous reset, active-high
//  ld_valid     in  1    image word valid
//  ld_data      in  DW   image word
//  ld_last      in  1    last image word (qualified by ld_valid)
//  ld_ready     out 1    controller accepts image word
//  cpu_rst      out 1    reset to avion_cpu
//  cpu_mar      in  AW   CPU address (MAR)
//  cpu_wdata    in  DW   CPU write data (MDRIn)
//  cpu_we       in  1    CPU write enable (RAMWr)
//  cpu_pc       in  AW   CPU program counter
//  cpu_rdata    out DW   RAM read data to CPU (MDROut)
//  ram_addr     out AW   to blram i_addr
//  ram_wdata    out DW   to blram i_ram_data_in
//  ram_we       out 1    to blram i_we
//  ram_rdata    in  DW   from blram o_ram_data_out; valid 1 cycle after ram_addr
//  dump_valid   out 1    dump word valid
//  dump_addr    out AW   address of dump word
//  dump_data    out DW   dump word
//  dump_ready   in  1    sink accepts dump word
//  restart      in  1    in DONE: return to LOAD
//  done         out 1    high in DONE
//  timeout      out 1    sticky: RUN ended by RUN_TIMEOUT
// BEHAVIOUR
//  Reset (async): state=LOAD, ld_ptr=0, cpu_rst=1, ld_ready=0, ram_we=0, dump_valid=0, done=0, timeout=0,
//   all counters 0. RAM contents untouched. ld_ready registered, high from first cycle after rst falls.
//  States LOAD -> RUN -> DUMP_RD -> DUMP_OUT -> DONE.
//  LOAD: ld_ready=1; on ld_valid&ld_ready write ld_data to RAM[ld_ptr] same cycle (ram_we comb), ld_ptr++.
//   Exit to RUN after the write where ld_last=1 or ld_ptr==MEM_DEPTH-1; ld_ready=0 from next cycle.
//  RUN: cpu_rst=0 (registered, first RUN cycle); ram_* = cpu_*; run_cnt++ each cycle.
//   stable_cnt++ when cpu_pc==pc_q and cpu_we=0, else cleared; pc_q<=cpu_pc every cycle.
//   stable_cnt==HALT_CYCLES -> DUMP_RD. Else run_cnt==RUN_TIMEOUT-1 -> timeout<=1, DUMP_RD.
//   Both same cycle: halt wins, timeout stays 0.
//  Leaving RUN: cpu_rst=1 next cycle; CPU write on the exit cycle still reaches RAM.
//  DUMP_RD: ram_we=0, ram_addr=DUMP_BASE+idx (mod 2^AW); next cycle DUMP_OUT latches ram_rdata.
//  DUMP_OUT: dump_valid=1, dump_addr/dump_data stable until dump_ready. On accept idx++;
//   idx==DUMP_LEN -> DONE, else DUMP_RD. DUMP_LEN=0: RUN exits straight to DONE.
//  DONE: done=1, cpu_rst=1, ram_we=0. restart=1 -> LOAD, ld_ptr=0, idx=0, timeout cleared.
//  restart outside DONE ignored. cpu_rdata=ram_rdata always. ram_addr=0, ram_we=0 in idle states.
//  rst mid-operation: immediate return to reset values; partial load or dump abandoned.
// TESTING
//  1 Load 3 words 0x101,0x0AB,0x3FF, ld_last on 3rd -> RAM[0..2] match; RUN entered, cpu_rst=0 next cycle.
//  2 64-word image, no ld_last, random ld_valid gaps -> RAM[0..63] match; RUN after RAM[63] written.
//  3 CPU model writes RAM[52]=50 then spins PC=10 -> 8 stable cycles later cpu_rst=1,
//    dump emits addr 52 data 50, done=1, timeout=0.
//  4 PC increments every cycle, RUN_TIMEOUT=100 -> timeout=1 after 100 RUN cycles, dump proceeds.
//  5 DUMP_BASE=62, DUMP_LEN=3, dump_ready low 5 cycles each word -> addrs 62,63,0 in order, data stable.
//  6 rst pulsed mid-RUN -> cpu_rst=1, state LOAD, RAM unchanged; restart in DONE -> reload at addr 0.

Source files
------------

// File: rtl/avion_boot_ctrl.sv
// Boot sequencer for avion_cpu: loads a program image into blram, runs the CPU until
// it halts or times out, then streams a window of RAM out through a valid/ready port.
module avion_boot_ctrl #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int MEM_DEPTH     = 64,
  parameter int HALT_CYCLES   = 8,
  parameter int RUN_TIMEOUT   = 4096,
  parameter int DUMP_BASE     = 52,
  parameter int DUMP_LEN      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     cpu_rst,
  input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_pc,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic                     ram_we,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     dump_valid,
  output logic [ADDRESS_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0]    dump_data,
  input  logic                     dump_ready,
  input  logic                     restart,
  output logic                     done,
  output logic                     timeout
);

  localparam int RCW = $clog2(RUN_TIMEOUT + 1);
  localparam int SCW = $clog2(HALT_CYCLES + 1);
  localparam int IW  = $clog2(DUMP_LEN + 1) + 1;

  typedef enum logic [2:0] {S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic                     r_ld_ready, r_cpu_rst, r_timeout, r_hold;
  logic [ADDRESS_WIDTH-1:0] r_ld_ptr, r_pc_q;
  logic [RCW-1:0]           r_run_cnt;
  logic [SCW-1:0]           r_stable_cnt;
  logic [IW-1:0]            r_idx;
  logic [DATA_WIDTH-1:0]    r_dump_data;
  logic                     w_ld_fire, w_halt, w_tmo, w_dump_last;
  logic [ADDRESS_WIDTH-1:0] w_dump_addr;

  assign w_ld_fire   = (r_state == S_LOAD) && ld_valid && r_ld_ready;
  assign w_halt      = (r_stable_cnt == SCW'(HALT_CYCLES));
  assign w_tmo       = (r_run_cnt == RCW'(RUN_TIMEOUT - 1));
  assign w_dump_last = ((r_idx + IW'(1)) == IW'(DUMP_LEN));
  assign w_dump_addr = ADDRESS_WIDTH'(DUMP_BASE) + ADDRESS_WIDTH'(r_idx);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:     if (w_ld_fire && (ld_last || r_ld_ptr == ADDRESS_WIDTH'(MEM_DEPTH - 1)))
                    w_next = S_RUN;
      S_RUN:      if (w_halt || w_tmo) w_next = (DUMP_LEN == 0) ? S_DONE : S_DUMP_RD;
      S_DUMP_RD:  w_next = S_DUMP_OUT;
      S_DUMP_OUT: if (dump_ready) w_next = w_dump_last ? S_DONE : S_DUMP_RD;
      S_DONE:     if (restart) w_next = S_LOAD;
      default:    w_next = S_LOAD;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (r_state)
      S_LOAD: begin
        ram_addr  = r_ld_ptr;
        ram_wdata = ld_data;
        ram_we    = w_ld_fire;
      end
      S_RUN: begin
        ram_addr  = cpu_mar;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
      end
      S_DUMP_RD: ram_addr = w_dump_addr;
      default: ;
    endcase
  end

  // The RAM port moves away in DUMP_OUT, so the word is taken live on the
  // first cycle and from the holding register while the sink stalls.
  assign dump_valid = (r_state == S_DUMP_OUT);
  assign dump_addr  = w_dump_addr;
  assign dump_data  = r_hold ? r_dump_data : ram_rdata;
  assign done       = (r_state == S_DONE);
  assign timeout    = r_timeout;
  assign ld_ready   = r_ld_ready;
  assign cpu_rst    = r_cpu_rst;
  assign cpu_rdata  = ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_ld_ready   <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_timeout    <= 1'b0;
      r_hold       <= 1'b0;
      r_ld_ptr     <= '0;
      r_pc_q       <= '0;
      r_run_cnt    <= '0;
      r_stable_cnt <= '0;
      r_idx        <= '0;
      r_dump_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_ld_ready <= (w_next == S_LOAD);
      r_cpu_rst  <= (w_next != S_RUN);
      r_pc_q     <= cpu_pc;
      if (w_ld_fire) r_ld_ptr <= r_ld_ptr + ADDRESS_WIDTH'(1);
      if (r_state == S_RUN) begin
        r_run_cnt    <= r_run_cnt + RCW'(1);
        r_stable_cnt <= (cpu_pc == r_pc_q && !cpu_we) ? r_stable_cnt + SCW'(1) : '0;
        if (w_tmo && !w_halt) r_timeout <= 1'b1;
      end else begin
        r_run_cnt    <= '0;
        r_stable_cnt <= '0;
      end
      if (r_state == S_DUMP_OUT) begin
        if (!r_hold) begin
          r_dump_data <= ram_rdata;
          r_hold      <= 1'b1;
        end
        if (dump_ready) begin
          r_idx  <= r_idx + IW'(1);
          r_hold <= 1'b0;
        end
      end
      if (r_state == S_DONE && restart) begin
        r_ld_ptr  <= '0;
        r_idx     <= '0;
        r_timeout <= 1'b0;
      end
    end
  end

endmodule
